// File: rtl/qei_decoder.sv
// Quadrature encoder receiver: 2-FF sync, glitch filter, x1/x2/x4 decode, wrapping position, step period.
// Pin change sampled at edge N: filtered state at N+1+FILTER_LEN, position/pulses at N+2+FILTER_LEN.
module qei_decoder #(
    parameter int FILTER_LEN = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        clear,
    input  logic [1:0]  mode,
    input  logic        dir_invert,
    input  logic [15:0] cnt_max,
    input  logic        enc_a,
    input  logic        enc_b,
    output logic [15:0] position,
    output logic        direction,
    output logic        count_pulse,
    output logic        overflow,
    output logic        underflow,
    output logic        phase_err,
    output logic        err_sticky,
    output logic [15:0] speed_period,
    output logic        speed_valid
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] FLEN = CW'(FILTER_LEN);

    logic [1:0]    sync1, sync2, cand, filt, filt_prev, warm;
    logic          filt_vld, prev_vld;
    logic [CW-1:0] flt_cnt, flt_nxt;
    logic [15:0]   period_cnt;
    logic [1:0]    idx_old, idx_new, idx_diff;
    logic          raw_up, raw_dn, raw_err, mode_ok, step, step_up;

    // Position of an {A,B} level along the forward (up) Gray sequence 00,10,11,01.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_idx = 2'd0;
            2'b10:   gray_idx = 2'd1;
            2'b11:   gray_idx = 2'd2;
            default: gray_idx = 2'd3;
        endcase
    endfunction

    always_comb flt_nxt = (flt_cnt != '0 && sync2 == cand) ? flt_cnt + 1'b1 : CW'(1);

    // warm holds off filtering until the synchroniser carries real pin samples, so the
    // first accepted level (loaded without decode) is never the reset value of the flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1     <= '0;
            sync2     <= '0;
            warm      <= '0;
            cand      <= '0;
            filt      <= '0;
            filt_prev <= '0;
            filt_vld  <= 1'b0;
            prev_vld  <= 1'b0;
            flt_cnt   <= '0;
        end else begin
            sync1     <= {enc_a, enc_b};
            sync2     <= sync1;
            warm      <= {warm[0], 1'b1};
            filt_prev <= filt;
            prev_vld  <= filt_vld;
            if (!warm[1] || (filt_vld && sync2 == filt)) begin
                flt_cnt <= '0;
            end else if (flt_nxt == FLEN) begin
                filt     <= sync2;
                filt_vld <= 1'b1;
                flt_cnt  <= '0;
            end else begin
                cand    <= sync2;
                flt_cnt <= flt_nxt;
            end
        end
    end

    always_comb begin
        idx_old  = gray_idx(filt_prev);
        idx_new  = gray_idx(filt);
        idx_diff = idx_new - idx_old;
        raw_up   = prev_vld && idx_diff == 2'd1;
        raw_dn   = prev_vld && idx_diff == 2'd3;
        raw_err  = prev_vld && idx_diff == 2'd2;
        case (mode)
            2'd1:    mode_ok = filt_prev[1] != filt[1];
            2'd2:    mode_ok = (filt_prev == 2'b00 && filt == 2'b10) ||
                               (filt_prev == 2'b10 && filt == 2'b00);
            default: mode_ok = 1'b1;
        endcase
        step    = enable && mode_ok && (raw_up || raw_dn);
        step_up = raw_up ^ dir_invert;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            position     <= '0;
            direction    <= 1'b0;
            count_pulse  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            phase_err    <= 1'b0;
            err_sticky   <= 1'b0;
            speed_period <= '0;
            speed_valid  <= 1'b0;
            period_cnt   <= '0;
        end else begin
            count_pulse <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            speed_valid <= 1'b0;
            phase_err   <= raw_err;
            err_sticky  <= (err_sticky & ~clear) | raw_err;
            if (clear) begin
                position   <= '0;
                period_cnt <= '0;
            end else if (enable) begin
                period_cnt <= (period_cnt == 16'hFFFF) ? 16'hFFFF : period_cnt + 16'd1;
                if (step) begin
                    count_pulse  <= 1'b1;
                    direction    <= step_up;
                    speed_valid  <= 1'b1;
                    speed_period <= (period_cnt == 16'hFFFF) ? 16'hFFFF : period_cnt + 16'd1;
                    period_cnt   <= '0;
                    if (step_up) begin
                        if (position >= cnt_max) begin
                            position <= '0;
                            overflow <= 1'b1;
                        end else begin
                            position <= position + 16'd1;
                        end
                    end else begin
                        if (position == 16'd0) begin
                            position  <= cnt_max;
                            underflow <= 1'b1;
                        end else begin
                            position <= position - 16'd1;
                        end
                    end
                end
            end
        end
    end
endmodule
